stream_demux2: RTL and testbench

STREAM_DEMUX2 -- requirements
Module: stream_demux2

---
 rtl/demux_pkg.sv | 13 +
 rtl/demux_slot.sv | 44 ++++
 rtl/stream_demux2.sv | 116 +++++++++++
 tb/tb_stream_demux2.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and default widths for the two-way stream demultiplexer.
package demux_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_CNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PKT0 = 2'd1,
      PKT1 = 2'd2
   } demux_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready register slot carrying payload and last flag.
// Refills in the same cycle it drains, so a stream passes at one beat per cycle.
module demux_slot
   import demux_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_data,
   input  logic              i_in_last,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic              o_out_last
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic              r_last;

   // Readiness looks only at this slot's own occupancy and its sink.
   assign o_in_ready  = !r_valid || i_out_ready;
   assign o_out_valid = r_valid;
   assign o_out_data  = r_data;
   assign o_out_last  = r_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_last  <= 1'b0;
      end else if (i_in_valid && o_in_ready) begin
         r_valid <= 1'b1;
         r_data  <= i_in_data;
         r_last  <= i_in_last;
      end else if (i_out_ready) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/stream_demux2.sv
// Packet-locked 1-to-2 stream demultiplexer with a register slot per output.
// Define DEMUX_CNT_EN to add per-output completed-packet counters (cnt0/cnt1).
module stream_demux2
   import demux_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_sel,
   input  logic              s_last,
   output logic              m0_valid,
   input  logic              m0_ready,
   output logic [DATA_W-1:0] m0_data,
   output logic              m0_last,
   output logic              m1_valid,
   input  logic              m1_ready,
   output logic [DATA_W-1:0] m1_data,
   output logic              m1_last
`ifdef DEMUX_CNT_EN
   ,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1
`endif
);

   demux_state_t r_state;
   demux_state_t w_state_next;
   logic         w_target;
   logic         w_accept;
   logic         w_rdy0;
   logic         w_rdy1;

   always_comb begin
      w_target = s_sel;
      case (r_state)
         PKT0:    w_target = 1'b0;
         PKT1:    w_target = 1'b1;
         default: w_target = s_sel;
      endcase
   end

   // rst_n gates s_ready so nothing is offered as accepted while reset is held.
   assign s_ready  = rst_n && (w_target ? w_rdy1 : w_rdy0);
   assign w_accept = s_valid && s_ready;

   always_comb begin
      w_state_next = r_state;
      if (w_accept) begin
         case (r_state)
            IDLE: begin
               if (!s_last) w_state_next = s_sel ? PKT1 : PKT0;
            end
            PKT0, PKT1: begin
               if (s_last) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   demux_slot #(.DATA_W(DATA_W)) u_slot0 (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_in_valid  (w_accept && !w_target),
      .o_in_ready  (w_rdy0),
      .i_in_data   (s_data),
      .i_in_last   (s_last),
      .o_out_valid (m0_valid),
      .i_out_ready (m0_ready),
      .o_out_data  (m0_data),
      .o_out_last  (m0_last)
   );

   demux_slot #(.DATA_W(DATA_W)) u_slot1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_in_valid  (w_accept && w_target),
      .o_in_ready  (w_rdy1),
      .i_in_data   (s_data),
      .i_in_last   (s_last),
      .o_out_valid (m1_valid),
      .i_out_ready (m1_ready),
      .o_out_data  (m1_data),
      .o_out_last  (m1_last)
   );

`ifdef DEMUX_CNT_EN
   logic [CNT_W-1:0] r_cnt0;
   logic [CNT_W-1:0] r_cnt1;

   // Counters wrap naturally at 2^CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else begin
         if (m0_valid && m0_ready && m0_last) r_cnt0 <= r_cnt0 + CNT_W'(1);
         if (m1_valid && m1_ready && m1_last) r_cnt1 <= r_cnt1 + CNT_W'(1);
      end
   end

   assign cnt0 = r_cnt0;
   assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_stream_demux2.sv
// Scoreboard bench for stream_demux2: stimulus pushes expected beats per port,
// a negedge monitor pops and compares every output handshake.
module tb_stream_demux2;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              s_valid, s_ready, s_sel, s_last;
   logic [DATA_W-1:0] s_data;
   logic              m0_valid, m0_ready, m0_last;
   logic              m1_valid, m1_ready, m1_last;
   logic [DATA_W-1:0] m0_data, m1_data;
   logic [CNT_W-1:0]  cnt0, cnt1;

   int n_vec = 0;
   int n_err = 0;

   logic [DATA_W:0] q0[$];
   logic [DATA_W:0] q1[$];
   logic            lock_valid = 1'b0;
   logic            lock_port  = 1'b0;

   always #5 clk = ~clk;

   stream_demux2 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .s_sel    (s_sel),
      .s_last   (s_last),
      .m0_valid (m0_valid),
      .m0_ready (m0_ready),
      .m0_data  (m0_data),
      .m0_last  (m0_last),
      .m1_valid (m1_valid),
      .m1_ready (m1_ready),
      .m1_data  (m1_data),
      .m1_last  (m1_last)
`ifdef DEMUX_CNT_EN
      ,
      .cnt0     (cnt0),
      .cnt1     (cnt1)
`endif
   );

`ifndef DEMUX_CNT_EN
   assign cnt0 = '0;
   assign cnt1 = '0;
`endif

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end else begin
         $display("ok   %s: %0h", nm, act);
      end
   endfunction

   // Monitor: a handshake visible at the negedge completes on the next posedge.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (m0_valid && m0_ready) begin
            if (q0.size() == 0) check("m0_unexpected_beat", {23'd0, m0_last, m0_data}, 32'hFFFF_FFFF);
            else check("m0_beat", {23'd0, m0_last, m0_data}, {23'd0, q0.pop_front()});
         end
         if (m1_valid && m1_ready) begin
            if (q1.size() == 0) check("m1_unexpected_beat", {23'd0, m1_last, m1_data}, 32'hFFFF_FFFF);
            else check("m1_beat", {23'd0, m1_last, m1_data}, {23'd0, q1.pop_front()});
         end
      end
   end

   // Presents a beat and holds it until accepted; leaves s_valid high for back-to-back use.
   task automatic send(input logic sel, input logic [7:0] d, input logic last, output int waited);
      logic tgt;
      s_valid = 1'b1; s_sel = sel; s_data = d; s_last = last;
      waited = 0;
      @(negedge clk);
      while (!s_ready) begin
         waited++;
         if (waited > 200) begin
            check("send_timeout", 32'd0, 32'd1);
            s_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      tgt = lock_valid ? lock_port : sel;
      if (tgt) q1.push_back({last, d});
      else     q0.push_back({last, d});
      if (last) lock_valid = 1'b0;
      else if (!lock_valid) begin
         lock_valid = 1'b1;
         lock_port  = sel;
      end
      @(posedge clk); #1;
   endtask

   task automatic idle();
      s_valid = 1'b0; s_sel = 1'b0; s_last = 1'b0; s_data = '0;
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check(nm, q0.size() + q1.size(), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      q0.delete(); q1.delete();
      lock_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int w;
      rst_n = 1'b0;
      m0_ready = 1'b1; m1_ready = 1'b1;
      idle();
      #3;
      check("rst_s_ready", s_ready, 0);
      check("rst_m0_valid", m0_valid, 0);
      check("rst_m1_valid", m1_valid, 0);
      check("rst_m0_data", m0_data, 0);
      check("rst_m1_last", m1_last, 0);
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_s_ready", s_ready, 1);
      @(posedge clk); #1;

      // Single beat to port 1; visible one cycle after acceptance.
      send(1'b1, 8'hA5, 1'b1, w);
      idle();
      check("single_m1_valid", m1_valid, 1);
      check("single_m0_valid", m0_valid, 0);
      drain("single_drain");

      // Packet lock: s_sel toggles after the first beat.
      send(1'b0, 8'h11, 1'b0, w);
      send(1'b1, 8'h22, 1'b0, w);
      send(1'b1, 8'h33, 1'b1, w);
      idle();
      drain("lock_drain");

      // Backpressure on port 0, then independence of port 1.
      m0_ready = 1'b0;
      send(1'b0, 8'h40, 1'b1, w);
      s_valid = 1'b1; s_sel = 1'b0; s_data = 8'h41; s_last = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_m0_valid", m0_valid, 1);
         check("bp_m0_data", m0_data, 32'h40);
         check("bp_s_ready", s_ready, 0);
      end
      @(posedge clk); #1;
      send(1'b1, 8'h70, 1'b0, w);
      check("indep_wait0", w, 0);
      send(1'b0, 8'h71, 1'b1, w);
      check("indep_wait1", w, 0);
      idle();
      repeat (2) @(posedge clk);
      #1 check("bp_still_held", m0_data, 32'h40);
      m0_ready = 1'b1;
      send(1'b0, 8'h41, 1'b0, w);
      check("tput_wait0", w, 0);
      send(1'b1, 8'h42, 1'b0, w);
      check("tput_wait1", w, 0);
      send(1'b0, 8'h43, 1'b1, w);
      check("tput_wait2", w, 0);
      idle();
      drain("bp_drain");

      // Reset mid-packet: buffered beat 2 and the port-0 lock are discarded.
      send(1'b0, 8'h01, 1'b0, w);
      send(1'b1, 8'h02, 1'b0, w);
      idle();
      #1 rst_n = 1'b0;
      #1;
      check("midrst_m0_valid", m0_valid, 0);
      check("midrst_m1_valid", m1_valid, 0);
      check("midrst_s_ready", s_ready, 0);
      q0.delete(); q1.delete();
      lock_valid = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      send(1'b1, 8'hB1, 1'b1, w);
      idle();
      check("post_midrst_m1_valid", m1_valid, 1);
      check("post_midrst_m0_valid", m0_valid, 0);
      drain("midrst_drain");

`ifdef DEMUX_CNT_EN
      do_reset();
      check("cnt_rst_cnt0", cnt0, 0);
      check("cnt_rst_cnt1", cnt1, 0);
      for (int i = 0; i < 17; i++) send(1'b1, 8'(i), 1'b1, w);
      idle();
      drain("cnt_drain");
      repeat (2) @(posedge clk);
      #1;
      check("cnt_wrap_cnt1", cnt1, 1);
      check("cnt_wrap_cnt0", cnt0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
